mpd_pkt_ctrl: RTL and testbench

Packet-sequencing controller for the malicious-packet-detection path. It drains one packet at a time from the input stream into a Packet Reference Table (PRT) slot, queries the bloom filter with the packet's IP pair, then either streams the packet out (safe) or discards it (unsafe, runt, oversize, timeout), and always frees the slot. It sits between the input FIFO, PRT, bloom filter and output FIFO, and fills the control role of the MPD top level. Unlike the bare top level, it adds a configurable depth and length limit, a verdict timeout, a bypass mode and saturating statistics.

---
 rtl/mpd_pkt_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mpd_pkt_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpd_pkt_ctrl.sv
// mpd_pkt_ctrl: drains one packet into a PRT slot, asks the bloom filter
// for a verdict, then streams the packet out or drops it and frees the slot.
// Ports: in_* input stream, out_* output stream (out_data registered),
// bf_* bloom query/verdict, EN_/RDY_ PRT methods, stat_* saturating counts.
module mpd_pkt_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_SLOTS       = 16,
  parameter int MAX_PKT_WORDS   = 64,
  parameter int VERDICT_TIMEOUT = 256,
  parameter int STAT_W          = 32,
  localparam int SLOT_W = $clog2(NUM_SLOTS),
  localparam int CNT_W  = $clog2(MAX_PKT_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  cfg_bypass,
  output logic                  bf_enable,
  output logic [31:0]           bf_src_ip,
  output logic [31:0]           bf_dest_ip,
  output logic [15:0]           bf_tag,
  input  logic                  bf_busy,
  input  logic                  bf_output_valid,
  input  logic                  bf_safe,
  input  logic [15:0]           bf_out_tag,
  output logic                  EN_start_writing_prt_entry,
  input  logic                  RDY_start_writing_prt_entry,
  input  logic [SLOT_W-1:0]     start_writing_prt_entry,
  output logic                  EN_write_prt_entry,
  input  logic                  RDY_write_prt_entry,
  output logic [DATA_WIDTH-1:0] write_prt_entry_data,
  output logic                  EN_finish_writing_prt_entry,
  input  logic                  RDY_finish_writing_prt_entry,
  output logic                  EN_invalidate_prt_entry,
  input  logic                  RDY_invalidate_prt_entry,
  output logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
  output logic                  EN_start_reading_prt_entry,
  input  logic                  RDY_start_reading_prt_entry,
  output logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
  output logic                  EN_read_prt_entry,
  input  logic                  RDY_read_prt_entry,
  input  logic [DATA_WIDTH-1:0] read_prt_entry,
  input  logic                  is_prt_slot_free,
  input  logic                  RDY_is_prt_slot_free,
  output logic [STAT_W-1:0]     stat_pass,
  output logic [STAT_W-1:0]     stat_drop,
  output logic [STAT_W-1:0]     stat_timeout,
  output logic                  err_tag_mismatch
);

  localparam int TMR_W = $clog2(VERDICT_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ALLOC, S_WRITE, S_FINISH, S_QUERY,
    S_WAIT, S_RSTART, S_RDATA, S_INVAL
  } state_t;

  state_t            st;
  logic [SLOT_W-1:0] slot;
  logic [CNT_W-1:0]  wcnt;
  logic [CNT_W-1:0]  wcnt_nxt;
  logic [CNT_W-1:0]  rcnt;
  logic [TMR_W-1:0]  tmr;
  logic              runt;
  logic              over;
  logic              pass;
  logic              tmo;
  logic              wfull;
  logic              acc;
  logic              tag_hit;
  logic              out_take;

  assign wfull    = (wcnt == CNT_W'(MAX_PKT_WORDS));
  assign wcnt_nxt = wfull ? wcnt : wcnt + CNT_W'(1);
  assign in_ready = (st == S_WRITE) &
                    (wfull | RDY_write_prt_entry);
  assign acc      = in_valid & in_ready;
  assign out_take = out_valid & out_ready;
  assign bf_tag   = 16'(slot);
  assign tag_hit  = (bf_out_tag == bf_tag);

  assign EN_start_writing_prt_entry =
    (st == S_ALLOC) & RDY_start_writing_prt_entry &
    RDY_is_prt_slot_free & is_prt_slot_free;
  assign EN_write_prt_entry   = acc & !wfull;
  assign write_prt_entry_data = in_data;
  assign EN_finish_writing_prt_entry =
    (st == S_FINISH) & RDY_finish_writing_prt_entry;
  assign bf_enable = (st == S_QUERY) & !bf_busy;
  assign EN_start_reading_prt_entry =
    (st == S_RSTART) & RDY_start_reading_prt_entry;
  assign start_reading_prt_entry_slot = slot;
  // Refill the output register only when it is empty or being drained.
  assign EN_read_prt_entry =
    (st == S_RDATA) & RDY_read_prt_entry &
    (rcnt != '0) & (!out_valid | out_ready);
  assign EN_invalidate_prt_entry =
    (st == S_INVAL) & RDY_invalidate_prt_entry;
  assign invalidate_prt_entry_slot = slot;
  assign err_tag_mismatch =
    (st == S_WAIT) & bf_output_valid & !tag_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_IDLE;
      slot         <= '0;
      wcnt         <= '0;
      rcnt         <= '0;
      tmr          <= '0;
      runt         <= 1'b0;
      over         <= 1'b0;
      pass         <= 1'b0;
      tmo          <= 1'b0;
      bf_src_ip    <= '0;
      bf_dest_ip   <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      stat_pass    <= '0;
      stat_drop    <= '0;
      stat_timeout <= '0;
    end else begin
      unique case (st)
        S_IDLE: if (in_valid) st <= S_ALLOC;
        S_ALLOC: if (EN_start_writing_prt_entry) begin
          slot <= start_writing_prt_entry;
          wcnt <= '0;
          runt <= 1'b0;
          over <= 1'b0;
          st   <= S_WRITE;
        end
        S_WRITE: if (acc) begin
          wcnt <= wcnt_nxt;
          if (wfull) over <= 1'b1;
          if (!wfull && wcnt == CNT_W'(0))
            bf_src_ip <= in_data[31:0];
          if (!wfull && wcnt == CNT_W'(1))
            bf_dest_ip <= in_data[31:0];
          // Runt means the IP pair was never completely stored.
          if (in_last) begin
            runt <= (wcnt_nxt < CNT_W'(2));
            st   <= S_FINISH;
          end
        end
        S_FINISH: if (EN_finish_writing_prt_entry) begin
          pass <= 1'b0;
          tmo  <= 1'b0;
          if (runt | over)     st <= S_INVAL;
          else if (cfg_bypass) st <= S_RSTART;
          else                 st <= S_QUERY;
        end
        S_QUERY: if (bf_enable) begin
          tmr <= '0;
          st  <= S_WAIT;
        end
        S_WAIT: begin
          tmr <= tmr + TMR_W'(1);
          if (bf_output_valid & tag_hit)
            st <= bf_safe ? S_RSTART : S_INVAL;
          else if (tmr == TMR_W'(VERDICT_TIMEOUT - 1)) begin
            tmo <= 1'b1;
            st  <= S_INVAL;
          end
        end
        S_RSTART: if (EN_start_reading_prt_entry) begin
          rcnt <= wcnt;
          st   <= S_RDATA;
        end
        S_RDATA: begin
          if (EN_read_prt_entry) begin
            out_data  <= read_prt_entry;
            out_valid <= 1'b1;
            out_last  <= (rcnt == CNT_W'(1));
            rcnt      <= rcnt - CNT_W'(1);
          end else if (out_take) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          if (out_take & out_last) begin
            pass <= 1'b1;
            st   <= S_INVAL;
          end
        end
        S_INVAL: if (EN_invalidate_prt_entry) begin
          if (pass) begin
            if (stat_pass != '1)
              stat_pass <= stat_pass + STAT_W'(1);
          end else if (stat_drop != '1) begin
            stat_drop <= stat_drop + STAT_W'(1);
          end
          if (tmo && stat_timeout != '1)
            stat_timeout <= stat_timeout + STAT_W'(1);
          st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpd_pkt_ctrl.sv
// tb_mpd_pkt_ctrl: table-driven packet scenarios against a small PRT and
// bloom responder model, plus reset-abort and recovery sequences.
module tb_mpd_pkt_ctrl;

  localparam int MAXW = 8;
  localparam int TO   = 20;
  localparam int SW   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [31:0] out_data;
  logic        cfg_bypass = 1'b0;
  logic        bf_enable;
  logic [31:0] bf_src_ip;
  logic [31:0] bf_dest_ip;
  logic [15:0] bf_tag;
  logic        bf_busy = 1'b0;
  logic        bf_output_valid = 1'b0;
  logic        bf_safe = 1'b0;
  logic [15:0] bf_out_tag = '0;
  logic        en_sw, en_wr, en_fin, en_inv, en_srd, en_rd;
  logic        rdy_wr = 1'b1;
  logic [3:0]  sw_slot = '0;
  logic [31:0] wr_data;
  logic [3:0]  inv_slot_o;
  logic [3:0]  srd_slot_o;
  logic [31:0] rd_data;
  logic [SW-1:0] stat_pass, stat_drop, stat_timeout;
  logic        err_tag_mismatch;

  always #5 clk = ~clk;

  mpd_pkt_ctrl #(
    .DATA_WIDTH(32), .NUM_SLOTS(16), .MAX_PKT_WORDS(MAXW),
    .VERDICT_TIMEOUT(TO), .STAT_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_data(out_data),
    .cfg_bypass(cfg_bypass),
    .bf_enable(bf_enable), .bf_src_ip(bf_src_ip),
    .bf_dest_ip(bf_dest_ip), .bf_tag(bf_tag),
    .bf_busy(bf_busy), .bf_output_valid(bf_output_valid),
    .bf_safe(bf_safe), .bf_out_tag(bf_out_tag),
    .EN_start_writing_prt_entry(en_sw),
    .RDY_start_writing_prt_entry(1'b1),
    .start_writing_prt_entry(sw_slot),
    .EN_write_prt_entry(en_wr),
    .RDY_write_prt_entry(rdy_wr),
    .write_prt_entry_data(wr_data),
    .EN_finish_writing_prt_entry(en_fin),
    .RDY_finish_writing_prt_entry(1'b1),
    .EN_invalidate_prt_entry(en_inv),
    .RDY_invalidate_prt_entry(1'b1),
    .invalidate_prt_entry_slot(inv_slot_o),
    .EN_start_reading_prt_entry(en_srd),
    .RDY_start_reading_prt_entry(1'b1),
    .start_reading_prt_entry_slot(srd_slot_o),
    .EN_read_prt_entry(en_rd),
    .RDY_read_prt_entry(1'b1),
    .read_prt_entry(rd_data),
    .is_prt_slot_free(1'b1), .RDY_is_prt_slot_free(1'b1),
    .stat_pass(stat_pass), .stat_drop(stat_drop),
    .stat_timeout(stat_timeout),
    .err_tag_mismatch(err_tag_mismatch)
  );

  // PRT model and event monitor
  logic [31:0] mem [16][8];
  logic [3:0]  wslot = '0, rslot = '0, inv_slot = '0;
  int wptr = 0, rptr = 0, cyc = 0;
  int n_wr = 0, n_inv = 0, n_srd = 0, n_bf = 0, n_err = 0;
  int n_last = 0, last_idx = 0, stall_viol = 0;
  int t_bf = 0, t_inv = 0, t_last = 0, t_first = 0;
  logic prev_ov = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] out_q [$];

  assign rd_data = mem[rslot][rptr[2:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en_sw) begin wslot <= sw_slot; wptr <= 0; end
    if (en_wr) begin
      mem[wslot][wptr[2:0]] <= wr_data;
      wptr <= wptr + 1;
      n_wr <= n_wr + 1;
    end
    if (en_inv) begin
      n_inv <= n_inv + 1;
      inv_slot <= inv_slot_o;
      t_inv <= cyc;
    end
    if (en_srd) begin rslot <= srd_slot_o; rptr <= 0; n_srd <= n_srd + 1; end
    if (en_rd) rptr <= rptr + 1;
    if (bf_enable) begin n_bf <= n_bf + 1; t_bf <= cyc; end
    if (err_tag_mismatch) n_err <= n_err + 1;
    if (in_valid && in_ready && in_last) t_last <= cyc;
    if (out_valid && !prev_ov) t_first <= cyc;
    prev_ov <= out_valid;
    if (prev_stall && out_valid && out_data !== prev_data)
      stall_viol <= stall_viol + 1;
    prev_stall <= out_valid && !out_ready;
    prev_data <= out_data;
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      if (out_last) begin
        n_last <= n_last + 1;
        last_idx <= out_q.size();
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int n; int byp; int busy; int bp; int verd;
    int e_out; int e_bf; int e_pass; int e_drop; int e_tmo; int lat;
  } vec_t;

  vec_t tbl [10];
  logic [31:0] w [16];

  task automatic send(input int n, input int rnd);
    int i = 0;
    int g = 0;
    while (i < n && g < 500) begin
      @(negedge clk);
      rdy_wr = rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = 1'b1;
      in_data = w[i];
      in_last = (i == n - 1);
      #1;
      if (in_ready) i++;
      g++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    rdy_wr = 1'b1;
    chk("send_done", i, n);
  endtask

  task automatic run_pkt(input vec_t v, input int k);
    int inv0, wr0, bf0, srd0, err0, last0, q0, g;
    logic [3:0] s;
    s = 4'((k * 3 + 5) % 16);
    for (int i = 0; i < 16; i++)
      w[i] = (i == 0) ? 32'h0A000001 : (i == 1) ? 32'h0A000002 :
             32'hD0000000 | 32'(k << 8) | 32'(i);
    inv0 = n_inv; wr0 = n_wr; bf0 = n_bf; srd0 = n_srd;
    err0 = n_err; last0 = n_last; q0 = out_q.size();
    sw_slot = s;
    cfg_bypass = v.byp != 0;
    bf_busy = v.busy != 0;
    out_ready = 1'b1;
    send(v.n, v.bp);
    if (v.busy != 0) begin
      repeat (3) @(negedge clk);
      chk("busy_hold", n_bf - bf0, 0);
      bf_busy = 1'b0;
    end
    if (v.verd != 0) begin
      g = 0;
      while (n_bf == bf0 && g < 100) begin @(negedge clk); g++; end
      chk("bf_seen", n_bf - bf0, 1);
      chk("bf_tag", bf_tag, 16'(s));
      repeat (v.verd == 3 ? 3 : 4) @(negedge clk);
      bf_output_valid = 1'b1;
      bf_safe = (v.verd == 1);
      bf_out_tag = (v.verd == 3) ? 16'(s ^ 4'h1) : 16'(s);
      #1;
      if (v.verd == 3) chk("err_pulse", err_tag_mismatch, 1);
      @(negedge clk);
      bf_output_valid = 1'b0;
      bf_safe = 1'b0;
    end
    g = 0;
    while (n_inv == inv0 && g < 400) begin
      @(negedge clk);
      out_ready = v.bp != 0 ? ~out_ready : 1'b1;
      g++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    chk("inv_count", n_inv - inv0, 1);
    chk("inv_slot", inv_slot, s);
    chk("writes", n_wr - wr0, v.n < MAXW ? v.n : MAXW);
    chk("bf_count", n_bf - bf0, v.e_bf);
    chk("start_read", n_srd - srd0, v.e_out != 0 ? 1 : 0);
    chk("out_words", out_q.size() - q0, v.e_out);
    for (int i = 0; i < v.e_out && i < out_q.size() - q0; i++)
      chk("out_word", out_q[q0 + i], w[i]);
    chk("n_last", n_last - last0, v.e_out != 0 ? 1 : 0);
    if (v.e_out != 0) chk("last_pos", last_idx, q0 + v.e_out);
    if (v.e_bf != 0 && v.n >= 2) begin
      chk("src_ip", bf_src_ip, 32'h0A000001);
      chk("dest_ip", bf_dest_ip, 32'h0A000002);
    end
    if (v.verd == 3) begin
      // TO full WAIT cycles sit between the query edge and the
      // invalidate edge.
      chk("timeout_cycles", t_inv - t_bf, TO + 1);
      chk("err_count", n_err - err0, 1);
    end
    // out_valid rises on the 3rd edge after the accepting edge; the
    // monitor sees the new value one edge later.
    if (v.lat != 0) chk("latency", t_first - t_last, 4);
    chk("stat_pass", stat_pass, v.e_pass);
    chk("stat_drop", stat_drop, v.e_drop);
    chk("stat_timeout", stat_timeout, v.e_tmo);
    chk("stall_viol", stall_viol, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    //            n  byp bsy bp vrd out bf pas drp tmo lat
    tbl[0] = '{4,  0, 1, 0, 1, 4,  1, 1, 0, 0, 0};
    tbl[1] = '{4,  0, 0, 0, 2, 0,  1, 1, 1, 0, 0};
    tbl[2] = '{1,  0, 0, 0, 0, 0,  0, 1, 2, 0, 0};
    tbl[3] = '{11, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0};
    tbl[4] = '{4,  0, 0, 0, 3, 0,  1, 1, 3, 1, 0};
    tbl[5] = '{3,  1, 0, 0, 0, 3,  0, 2, 3, 1, 1};
    tbl[6] = '{6,  0, 0, 1, 1, 6,  1, 3, 3, 1, 0};
    tbl[7] = '{8,  1, 0, 0, 0, 8,  0, 3, 3, 1, 0};
    tbl[8] = '{2,  0, 0, 0, 1, 2,  1, 3, 3, 1, 0};
    tbl[9] = '{2,  1, 0, 0, 0, 2,  0, 1, 0, 0, 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stats", {stat_pass, stat_drop, stat_timeout}, 0);
    chk("rst_en", {en_sw, en_wr, en_fin, en_inv, en_srd, en_rd}, 0);

    for (int k = 0; k < 9; k++) run_pkt(tbl[k], k);

    // Abort a stalled READ_DATA with reset.
    for (int i = 0; i < 16; i++) w[i] = 32'hE0000000 | 32'(i);
    sw_slot = 4'd9;
    cfg_bypass = 1'b1;
    out_ready = 1'b0;
    send(8, 0);
    g = 0;
    while (!out_valid && g < 50) begin @(negedge clk); g++; end
    chk("rd_started", out_valid, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ab_out_valid", out_valid, 0);
    chk("ab_out_last", out_last, 0);
    chk("ab_out_data", out_data, 0);
    chk("ab_en", {en_sw, en_wr, en_fin, en_inv, en_srd, en_rd}, 0);
    chk("ab_bf", {bf_enable, err_tag_mismatch, in_ready}, 0);
    chk("ab_bf_data", {bf_src_ip, bf_dest_ip, bf_tag}, 0);
    chk("ab_slots", {inv_slot_o, srd_slot_o}, 0);
    chk("ab_stats", {stat_pass, stat_drop, stat_timeout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    run_pkt(tbl[9], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
